// File: rtl/mult_div_unit.sv
// Iterative 32-bit signed multiply / divide unit: one bit per cycle over
// operand magnitudes, with the signs applied in a single fix-up cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MDCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] r_opnd;     // multiplicand or divisor magnitude
  logic [4:0]  r_cnt;
  logic        r_op;
  logic        r_neg_res;
  logic        r_neg_a;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_div0;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic [32:0] w_sum;
  logic [32:0] w_trial;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_a_mag    = A[31] ? -A : A;
  assign w_b_mag    = B[31] ? -B : B;
  assign w_div_zero = MDCtrl && (B == 32'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_div_zero ? DONE : CALC;
      CALC: if (r_cnt == 5'd31) w_next = FIN;
      FIN:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One iteration step: shift-add for mult, restoring shift-subtract for div.
  always_comb begin
    w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_trial    = {r_acc[63:32], r_acc[31]} - {1'b0, r_opnd};
    w_acc_next = {w_sum, r_acc[31:1]};
    if (r_op) begin
      if (!w_trial[32]) w_acc_next = {w_trial[31:0], r_acc[30:0], 1'b1};
      else              w_acc_next = {r_acc[62:0], 1'b0};
    end
  end

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_neg_a   ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: if (start) begin
          r_div0    <= w_div_zero;
          r_busy    <= !w_div_zero;
          r_op      <= MDCtrl;
          r_neg_res <= A[31] ^ B[31];
          r_neg_a   <= A[31];
          r_cnt     <= '0;
          r_opnd    <= MDCtrl ? w_b_mag : w_a_mag;
          r_acc     <= {32'd0, MDCtrl ? w_a_mag : w_b_mag};
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          r_acc <= w_acc_next;
        end
        FIN: begin
          r_hi <= r_op ? w_rem : w_prod[63:32];
          r_lo <= r_op ? w_quo : w_prod[31:0];
        end
        DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results come from plain
// 64-bit signed arithmetic and are matched against each done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        MDCtrl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        busy, done, div0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MDCtrl(MDCtrl),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one request; caller must be positioned just after a falling edge.
  task automatic issue(input logic md, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    start  = 1'b1;
    MDCtrl = md;
    A      = a;
    B      = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (md && b == 32'd0) begin
      e.cyc  = cyc + 2;
      e.div0 = 1'b1;
    end else begin
      e.cyc  = cyc + 35;
      e.div0 = 1'b0;
      if (!md) begin
        p    = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end else begin
        q    = sa / sb;
        r    = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    MDCtrl = $urandom_range(0, 1);
    A      = $urandom;
    B      = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("HI", {32'd0, HI}, {32'd0, e.hi});
        check("LO", {32'd0, LO}, {32'd0, e.lo});
        check("div0", {63'd0, div0}, {63'd0, e.div0});
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    int busy_cnt;
    logic        md;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {HI, LO}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Mult 7 x -3, counting busy cycles
    issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    busy_cnt = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(busy_cnt), 64'd34);
    drain();

    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    drain();

    // Divide by zero keeps HI/LO, never raises busy, div0 sticky until next start
    issue(1'b1, 32'h1234_5678, 32'h0000_0000);
    check("div0_busy_low", {63'd0, busy}, 64'd0);
    check("div0_flag", {63'd0, div0}, 64'd1);
    drain();
    repeat (3) @(negedge clk);
    check("div0_sticky", {63'd0, div0}, 64'd1);

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div0_cleared", {63'd0, div0}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    drain();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    drain();

    // Start during CALC must be ignored
    issue(1'b1, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; MDCtrl = 1'b0; A = 32'h5555_5555; B = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Start held high for several IDLE cycles launches one operation
    issue(1'b0, 32'hFFFF_FF00, 32'h0001_0001);
    start = 1'b1; MDCtrl = 1'b0; A = 32'h0000_0009; B = 32'h0000_0009;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset at CALC cycle 10 aborts, then the first low-reset edge accepts a start
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outputs", {HI, LO}, 64'd0);
    check("abort_flags", {61'd0, busy, done, div0}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    check("abort_hold", {HI, LO}, 64'd0);
    reset = 1'b0;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    for (int i = 0; i < 40; i++) begin
      md = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h0000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0000_0000;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h0000_0001;
        3:       b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      @(negedge clk);
      issue(md, a, b);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
